// File: rtl/seq_pkg.sv
// Shared types, default table contents and the pointer advance rule
// for the sequence playback controller.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
  typedef enum logic [1:0] {WRAP = 2'd0, BOUNCE = 2'd1, ONESHOT = 2'd2} mode_e;

  localparam int SEQ_LEN = 8;
  localparam int DEFAULT_SEQ [SEQ_LEN] = '{5, 10, 15, 4, 9, 14, 3, 8};

  typedef struct packed {
    int unsigned pos;
    logic        dir;
    logic        at_end;
  } adv_t;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return BOUNCE;
      2'd2:    return ONESHOT;
      default: return WRAP;
    endcase
  endfunction

  // One pointer move; depth must be a power of two. at_end flags the
  // endpoint in the current direction so one-shot can stop there.
  function automatic adv_t advance(input int unsigned pos, input logic dir,
                                   input mode_e mode, input int unsigned depth);
    adv_t r;
    r.at_end = dir ? (pos == depth - 1) : (pos == 0);
    r.dir    = dir;
    r.pos    = pos;
    case (mode)
      BOUNCE: begin
        if (r.at_end) begin
          r.dir = ~dir;
          r.pos = dir ? pos - 1 : pos + 1;
        end else begin
          r.pos = dir ? pos + 1 : pos - 1;
        end
      end
      ONESHOT: begin
        if (!r.at_end) r.pos = dir ? pos + 1 : pos - 1;
      end
      default: begin
        r.pos = dir ? ((pos + 1) & (depth - 1)) : ((pos + depth - 1) & (depth - 1));
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_play_ctrl_rise_det.sv
// Registered rising-edge detector: rise is high on the edge where d
// samples 1 and the previous sample was 0.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/seq_play_ctrl.sv
// Sequence playback controller: 8-entry writable table walked by a pointer
// on the 2 Hz tick. Optional BCD split outputs under SEQ_PLAY_CTRL_BCD_EN.
module seq_play_ctrl
  import seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEPTH    = 8,
  parameter int IDX_W    = 3,
  parameter int SLOW_DIV = 2
) (
  input  logic             clk_500ms,
  input  logic             reset,
  input  logic             timeS,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
`ifdef SEQ_PLAY_CTRL_BCD_EN
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
`endif
  output logic [IDX_W-1:0] pos,
  output logic [N-1:0]     value,
  output logic             running,
  output logic             done
);

  localparam int TW = $clog2(SLOW_DIV);

  state_e           state;
  logic             dir;
  logic [TW-1:0]    tick_cnt;
  logic [N-1:0]     table_q [DEPTH];
  logic             start_rise, stop_rise, step_rise;
  logic             start_go, stop_go, step_go;
  logic             slow_hit;
  mode_e            mode_d;
  adv_t             adv;
  logic [IDX_W-1:0] new_pos;

  rise_det u_start (.clk(clk_500ms), .reset(reset), .d(start), .rise(start_rise));
  rise_det u_stop  (.clk(clk_500ms), .reset(reset), .d(stop),  .rise(stop_rise));
  rise_det u_step  (.clk(clk_500ms), .reset(reset), .d(step),  .rise(step_rise));

  // stop outranks start, which outranks step; losers on the same edge are dropped
  assign stop_go  = stop_rise;
  assign start_go = start_rise & ~stop_rise;
  assign step_go  = step_rise & ~stop_rise & ~start_rise;

  assign mode_d   = decode_mode(mode);
  assign adv      = advance(32'(pos), dir, mode_d, 32'(DEPTH));
  assign new_pos  = IDX_W'(adv.pos);
  assign slow_hit = timeS || (tick_cnt == TW'(SLOW_DIV - 1));

  always_ff @(posedge clk_500ms or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      dir      <= 1'b1;
      tick_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_go) begin
            state    <= RUN;
            running  <= 1'b1;
            done     <= 1'b0;
            pos      <= up ? '0 : IDX_W'(DEPTH - 1);
            dir      <= up;
            tick_cnt <= '0;
          end else if (state == DONE && stop_go) begin
            state <= IDLE;
            done  <= 1'b0;
            pos   <= '0;
          end else if (state == IDLE && step_go) begin
            pos <= new_pos;
            dir <= adv.dir;
          end
        end
        RUN: begin
          if (stop_go) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (slow_hit) begin
            tick_cnt <= '0;
            if (mode_d == ONESHOT && adv.at_end) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              pos <= new_pos;
              dir <= adv.dir;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PAUSE: begin
          if (stop_go) begin
            state <= IDLE;
            pos   <= '0;
            dir   <= 1'b1;
          end else if (start_go) begin
            state    <= RUN;
            running  <= 1'b1;
            tick_cnt <= '0;
          end else if (step_go) begin
            pos <= new_pos;
            dir <= adv.dir;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table is writable in every state; reset restores the default sequence
  always_ff @(posedge clk_500ms or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= N'(DEFAULT_SEQ[i % SEQ_LEN]);
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign value = table_q[pos];

`ifdef SEQ_PLAY_CTRL_BCD_EN
  assign bcd_tens  = 4'(value / 10);
  assign bcd_units = 4'(value % 10);
`endif

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Directed plus randomized bench for seq_play_ctrl against a behavioural
// model of the playback rules.
module tb_seq_play_ctrl;

  logic       clk_500ms = 1'b0;
  logic       reset, timeS, up, start, stop, step, wr_en;
  logic [1:0] mode;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [2:0] pos;
  logic [3:0] value;
  logic       running, done;
`ifdef SEQ_PLAY_CTRL_BCD_EN
  logic [3:0] bcd_tens, bcd_units;
`endif

  seq_play_ctrl dut (
    .clk_500ms(clk_500ms), .reset(reset), .timeS(timeS), .up(up), .mode(mode),
    .start(start), .stop(stop), .step(step), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef SEQ_PLAY_CTRL_BCD_EN
    .bcd_tens(bcd_tens), .bcd_units(bcd_units),
`endif
    .pos(pos), .value(value), .running(running), .done(done)
  );

  always #5 clk_500ms = ~clk_500ms;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_state, m_pos, m_dir, m_tick;
  int m_tab [8];
  int p_start, p_stop, p_step;
  const int DEF [8] = '{5, 10, 15, 4, 9, 14, 3, 8};

  int exp_wrap [9]  = '{5, 10, 15, 4, 9, 14, 3, 8, 5};
  int exp_slow [6]  = '{5, 5, 10, 10, 15, 15};
  int exp_once [8]  = '{8, 3, 14, 9, 4, 15, 10, 5};
  int exp_bnc  [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_pos = 0; m_dir = 1; m_tick = 0;
    p_start = 0; p_stop = 0; p_step = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = DEF[i];
  endtask

  // One move of the pointer; hit reports a one-shot endpoint (pos held)
  task automatic model_move(output bit hit);
    bit at_end;
    int md;
    at_end = (m_dir == 1 && m_pos == 7) || (m_dir == 0 && m_pos == 0);
    md = (mode == 2'd3) ? 0 : int'(mode);
    hit = 0;
    if (md == 1 && at_end) begin
      m_dir = 1 - m_dir;
      m_pos = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
    end else if (md == 2 && at_end) begin
      hit = 1;
    end else begin
      m_pos = (m_pos + ((m_dir == 1) ? 1 : 7)) % 8;
    end
  endtask

  task automatic model_edge();
    bit ev_stop, ev_start, ev_step, hit;
    ev_stop  = stop  && !p_stop;
    ev_start = start && !p_start && !ev_stop;
    ev_step  = step  && !p_step && !ev_stop && !ev_start;
    p_stop = int'(stop); p_start = int'(start); p_step = int'(step);
    case (m_state)
      M_IDLE, M_DONE: begin
        if (ev_start) begin
          m_state = M_RUN; m_pos = up ? 0 : 7; m_dir = int'(up); m_tick = 0;
        end else if (m_state == M_DONE && ev_stop) begin
          m_state = M_IDLE; m_pos = 0;
        end else if (m_state == M_IDLE && ev_step) begin
          model_move(hit);
        end
      end
      M_RUN: begin
        if (ev_stop) m_state = M_PAUSE;
        else if (timeS || m_tick == 1) begin
          m_tick = 0;
          model_move(hit);
          if (hit) m_state = M_DONE;
        end else m_tick++;
      end
      default: begin
        if (ev_stop) begin
          m_state = M_IDLE; m_pos = 0; m_dir = 1;
        end else if (ev_start) begin
          m_state = M_RUN; m_tick = 0;
        end else if (ev_step) model_move(hit);
      end
    endcase
    if (wr_en) m_tab[wr_addr] = int'(wr_data);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pos"}, pos, m_pos);
    check({tag, "_value"}, value, m_tab[m_pos]);
    check({tag, "_running"}, running, m_state == M_RUN);
    check({tag, "_done"}, done, m_state == M_DONE);
`ifdef SEQ_PLAY_CTRL_BCD_EN
    check({tag, "_tens"}, bcd_tens, m_tab[m_pos] / 10);
    check({tag, "_units"}, bcd_units, m_tab[m_pos] % 10);
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk_500ms);
    if (!reset) model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    reset = 1; timeS = 1; up = 1; mode = 0; start = 0; stop = 0; step = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    model_reset();
    tick("rst");
    tick("rst");
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      tick("idle");
      check("idle_value_const", value, 5);
      check("idle_pos_const", pos, 0);
    end

    // wrap, fast
    start = 1; tick("wrap_start"); start = 0;
    check("wrap_v0", value, exp_wrap[0]);
    for (int i = 1; i < 9; i++) begin
      tick("wrap");
      check($sformatf("wrap_v%0d", i), value, exp_wrap[i]);
    end
    check("wrap_pos_zero", pos, 0);
    stop = 1; tick("pause"); stop = 0; tick("pause_hold");
    stop = 1; tick("to_idle"); stop = 0;
    check("to_idle_running", running, 0);

    // wrap, slow
    timeS = 0;
    start = 1; tick("slow_start"); start = 0;
    check("slow_v0", value, exp_slow[0]);
    for (int i = 1; i < 6; i++) begin
      tick("slow");
      check($sformatf("slow_v%0d", i), value, exp_slow[i]);
    end
    stop = 1; tick("slow_pause"); stop = 0; tick("slow_hold");
    stop = 1; tick("slow_idle"); stop = 0;

    // one-shot, down
    timeS = 1; mode = 2; up = 0;
    start = 1; tick("once_start"); start = 0;
    check("once_v0", value, exp_once[0]);
    for (int i = 1; i < 8; i++) begin
      tick("once");
      check($sformatf("once_v%0d", i), value, exp_once[i]);
    end
    tick("once_end");
    check("once_done", done, 1);
    check("once_hold", value, 5);
    step = 1; tick("once_step"); step = 0;
    check("once_step_hold", value, 5);
    check("once_step_done", done, 1);
    stop = 1; tick("once_stop"); stop = 0;
    check("once_stop_pos", pos, 0);
    check("once_stop_done", done, 0);
    tick("once_idle");

    // bounce, up
    mode = 1; up = 1;
    start = 1; tick("bnc_start"); start = 0;
    check("bnc_p0", pos, 0);
    for (int i = 0; i < 15; i++) begin
      tick("bnc");
      check($sformatf("bnc_p%0d", i + 1), pos, exp_bnc[i]);
    end

    // stop and start together while running: stop wins
    start = 1; stop = 1; tick("both"); start = 0; stop = 0;
    check("both_running", running, 0);
    check("both_pos", pos, 1);

    // write under the pointer, then single step and resume
    wr_en = 1; wr_addr = 3'd1; wr_data = 4'd0; tick("wr"); wr_en = 0;
    check("wr_value", value, 0);
    step = 1; tick("pstep"); step = 0;
    check("pstep_pos", pos, 2);
    tick("pstep_hold");
    start = 1; tick("resume"); start = 0;
    check("resume_pos", pos, 2);
    tick("resume_run");
    check("resume_adv", pos, 3);

    // asynchronous reset mid-cycle restores pointer and table
    tick("pre_rst");
    #2 reset = 1;
    #1;
    model_reset();
    check("arst_value", value, 5);
    check("arst_pos", pos, 0);
    check("arst_running", running, 0);
    #2 reset = 0;
    mode = 0;
    step = 1; tick("arst_step"); step = 0;
    check("arst_tab1", value, 10);

    // randomized mix
    for (int n = 0; n < 400; n++) begin
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 9) == 0);
      step    = ($urandom_range(0, 3) == 0);
      timeS   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) up = 1'($urandom_range(0, 1));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      tick("rnd");
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1;
        #1 model_reset();
        compare_all("rnd_rst");
        #1 reset = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_play_ctrl.md
Name: seq_play_ctrl

Overview:
Playback controller for the 2-digit sequence display. It holds a writable 8-entry sequence table and sequences a position pointer through it on the 2 Hz tick clock. Features: run/pause/single-step, fast/slow rate, direction, and wrap/bounce/one-shot end behaviour. Its value output feeds the tens/units split and the 7-segment decoders.

Parameters:
N, 4, width of each sequence value
DEPTH, 8, number of table entries (power of two)
IDX_W, 3, pointer width, equal to log2(DEPTH)
SLOW_DIV, 2, tick edges per step when timeS=0 (≥2)

Ports:
clk_500ms  in  1  step clock (2 Hz tick)
reset  in  1  asynchronous, active-high
timeS  in  1  1 = step every edge, 0 = step every SLOW_DIV edges
up  in  1  direction loaded at start: 1 increment, 0 decrement
mode  in  2  0 wrap, 1 bounce, 2 one-shot, 3 treated as wrap
start  in  1  level; rising edge = start/resume
stop  in  1  level; rising edge = pause/abort
step  in  1  level; rising edge = single step when not running
wr_en  in  1  table write strobe, sampled at clk edge
wr_addr  in  IDX_W  table write address
wr_data  in  N  table write data
pos  out  IDX_W  current pointer
value  out  N  table[pos], combinational
running  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset, asynchronous: state IDLE; pos=0; dir=1; tick_cnt=0; running=0; done=0; edge-detector history=0.
- Reset also loads the table with 5,10,15,4,9,14,3,8, so value=5.
- Edge detection: an event fires at the edge where the input samples 1 and the previous sample was 0. The action takes effect on that same edge.
- Event priority: stop > start > step. A lower-priority event on the same edge is discarded.
- States are IDLE, RUN, PAUSE, DONE.
- IDLE + start: go to RUN; pos = up ? 0 : DEPTH-1; dir=up; tick_cnt=0.
- IDLE + step: advance once per the mode rules; stay IDLE.
- RUN + stop: go to PAUSE; pos and dir frozen.
- RUN stepping: each edge, if timeS=1 or tick_cnt==SLOW_DIV-1, advance and clear tick_cnt; else increment tick_cnt.
- RUN: a timeS change takes effect on the next edge. up is ignored while running.
- PAUSE + start: return to RUN with tick_cnt=0; pos and dir are retained.
- PAUSE + step: advance once.
- PAUSE + stop: go to IDLE with pos=0 and dir=1.
- DONE + start: behaves as IDLE + start.
- DONE + stop: go to IDLE with pos=0.
- DONE + step: ignored.
- Advance rule, wrap: pos ± 1 modulo DEPTH.
- Advance rule, bounce: at an endpoint (pos=DEPTH-1 with dir=1, or pos=0 with dir=0), flip dir and move one step inward. The endpoint is not repeated.
- Advance rule, one-shot: at an endpoint in RUN, go to DONE with pos held. A step at an endpoint in IDLE/PAUSE holds pos.
- Table writes happen on any edge in any state. value reflects a write to table[pos] from that edge on.
- Write and advance on the same edge: value shows table[new pos], including the newly written data.
- running = (state==RUN). done = (state==DONE). Both registered with the state.
- value has no pipeline lag: it changes on the same edge as pos.

Optional Feature:
SEQ_PLAY_CTRL_BCD_EN
- Defined: adds outputs bcd_tens[3:0] and bcd_units[3:0] = value/10 and value%10, combinational; both 0 when value=0.
- Undefined: these ports do not exist, and the downstream split stays external.

Decomposition:
- Package seq_pkg holds: state enum (IDLE, RUN, PAUSE, DONE); mode enum (WRAP, BOUNCE, ONESHOT); localparam array DEFAULT_SEQ = {5,10,15,4,9,14,3,8}.
- One sub-module, rise_det (1-bit registered rising-edge detector, async reset), instantiated for start, stop and step.
- The pointer/advance logic is a function inside the package.

Test Plan:
- Reset released, no inputs: pos=0, value=5, running=0, done=0, held for 10 edges.
- mode=0, up=1, timeS=1, start pulse: value on successive edges is 5,10,15,4,9,14,3,8,5; pos wraps 7→0.
- Same but timeS=0: each value is held exactly 2 edges (5,5,10,10,15,...).
- mode=2, up=0, timeS=1, start: value runs 8,3,14,9,4,15,10,5, then done=1 and value stays 5; a further step changes nothing; stop returns to IDLE with pos=0.
- mode=1, up=1: pos runs 0..7,6,5,...,0,1, with no duplicate at either endpoint.
- In RUN, stop and start rise on the same edge: goes to PAUSE.
- Then write addr=pos data=0: value=0 on the next edge; a step advances exactly one; start resumes from that pos.
- Assert reset mid-run: value=5 asynchronously and the table restores its defaults.
